// File: rtl/debounce_pkg.sv
// Shared constants and types for the multi-channel button/switch debouncer.
package debounce_pkg;

    localparam int unsigned DEFAULT_N_CH  = 4;
    localparam int unsigned DEFAULT_CNT_W = 11;

    // COUNTING whenever a candidate level is being timed (cnt != 0 or sync2 != level).
    typedef enum logic {
        STABLE   = 1'b0,
        COUNTING = 1'b1
    } deb_state_e;

endpackage

// File: rtl/debounce_channel.sv
// One debounce channel: 2-FF synchroniser, stability counter, level, edge pulses, sticky bounce flag.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int unsigned CNT_W       = DEFAULT_CNT_W,
    parameter logic        RESET_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             btn_in,
    input  logic [CNT_W-1:0] stable_cycles,
    input  logic             clear_flags,
    output logic             level,
    output logic             rise,
    output logic             fall,
    output logic             flag,
    output logic             rise_c,
    output logic             fall_c
);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             level_q, level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             flag_q, flag_d;
    logic [CNT_W-1:0] thresh_m1;
    deb_state_e       state_c;

    // A zero threshold is treated as one cycle.
    assign thresh_m1 = (stable_cycles == '0) ? '0 : stable_cycles - CNT_W'(1);

    assign state_c = ((cnt_q != '0) || (sync2_q != level_q)) ? COUNTING : STABLE;

    always_comb begin
        sync1_d = btn_in;
        sync2_d = sync1_q;
        level_d = level_q;
        cnt_d   = cnt_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        flag_d  = clear_flags ? 1'b0 : flag_q;

        if (sync2_q == level_q) begin
            cnt_d = '0;
            // Input reverted before the count completed; set wins over clear.
            if (cnt_q != '0) begin
                flag_d = 1'b1;
            end
        end else if (cnt_q >= thresh_m1) begin
            level_d = sync2_q;
            cnt_d   = '0;
            rise_d  = sync2_q;
            fall_d  = ~sync2_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= RESET_LEVEL;
            sync2_q <= RESET_LEVEL;
            level_q <= RESET_LEVEL;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            flag_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            flag_q  <= flag_d;
        end
    end

    assign level  = level_q;
    assign rise   = rise_q;
    assign fall   = fall_q;
    assign flag   = flag_q;
    assign rise_c = rise_d;
    assign fall_c = fall_d;

    a_no_pulse_from_stable : assert property (
        @(posedge clk) disable iff (reset) (state_c == STABLE) |=> !(rise_q || fall_q));

    a_pulses_exclusive : assert property (
        @(posedge clk) disable iff (reset) !(rise_q && fall_q));

endmodule

// File: rtl/multi_debounce.sv
// N_CH independent debounce channels sharing one threshold, plus a registered any-edge summary.
module multi_debounce
    import debounce_pkg::*;
#(
    parameter int unsigned N_CH        = DEFAULT_N_CH,
    parameter int unsigned CNT_W       = DEFAULT_CNT_W,
    parameter logic        RESET_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_CH-1:0]  btn_input,
    input  logic [CNT_W-1:0] stable_cycles,
    input  logic             clear_flags,
    output logic [N_CH-1:0]  debounce_output,
    output logic [N_CH-1:0]  rise_pulse,
    output logic [N_CH-1:0]  fall_pulse,
    output logic [N_CH-1:0]  bounce_flag,
    output logic             any_change
);

    logic [N_CH-1:0] rise_c;
    logic [N_CH-1:0] fall_c;
    logic            any_change_q, any_change_d;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        debounce_channel #(
            .CNT_W       (CNT_W),
            .RESET_LEVEL (RESET_LEVEL)
        ) u_ch (
            .clk           (clk),
            .reset         (reset),
            .btn_in        (btn_input[i]),
            .stable_cycles (stable_cycles),
            .clear_flags   (clear_flags),
            .level         (debounce_output[i]),
            .rise          (rise_pulse[i]),
            .fall          (fall_pulse[i]),
            .flag          (bounce_flag[i]),
            .rise_c        (rise_c[i]),
            .fall_c        (fall_c[i])
        );
    end

    // Built from the next-cycle pulse values so it lines up with the registered pulses.
    always_comb begin
        any_change_d = |(rise_c | fall_c);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            any_change_q <= 1'b0;
        end else begin
            any_change_q <= any_change_d;
        end
    end

    assign any_change = any_change_q;

endmodule

// File: tb/tb_multi_debounce.sv
// Directed bench for multi_debounce: vector table for reset/clean press, hand sequences for corner cases.
module tb_multi_debounce;

    localparam int unsigned N_CH  = 4;
    localparam int unsigned CNT_W = 11;

    logic             clk = 1'b0;
    logic             reset;
    logic [N_CH-1:0]  btn_input;
    logic [CNT_W-1:0] stable_cycles;
    logic             clear_flags;
    logic [N_CH-1:0]  debounce_output;
    logic [N_CH-1:0]  rise_pulse;
    logic [N_CH-1:0]  fall_pulse;
    logic [N_CH-1:0]  bounce_flag;
    logic             any_change;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    multi_debounce #(
        .N_CH        (N_CH),
        .CNT_W       (CNT_W),
        .RESET_LEVEL (1'b0)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .btn_input       (btn_input),
        .stable_cycles   (stable_cycles),
        .clear_flags     (clear_flags),
        .debounce_output (debounce_output),
        .rise_pulse      (rise_pulse),
        .fall_pulse      (fall_pulse),
        .bounce_flag     (bounce_flag),
        .any_change      (any_change)
    );

    typedef struct {
        logic             rst;
        logic [N_CH-1:0]  btn;
        logic [CNT_W-1:0] stab;
        logic             clr;
        logic [N_CH-1:0]  out;
        logic [N_CH-1:0]  rise;
        logic [N_CH-1:0]  fall;
        logic [N_CH-1:0]  flag;
        logic             any;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic rst, input logic [N_CH-1:0] btn, input logic [CNT_W-1:0] stab,
                       input logic [N_CH-1:0] out, input logic [N_CH-1:0] rise,
                       input logic [N_CH-1:0] fall, input logic any);
        vec_t v;
        v.rst = rst; v.btn = btn; v.stab = stab; v.clr = 1'b0;
        v.out = out; v.rise = rise; v.fall = fall; v.flag = '0; v.any = any;
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act != exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Inputs are set between edges; outputs are read 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Steps until the selected pulse appears on channel ch; returns its 1-based step number, 0 on timeout.
    task automatic wait_pulse(input int ch, input bit want_rise, input int budget, output int n);
        int i;
        n = 0;
        i = 0;
        while (n == 0 && i < budget) begin
            step();
            i++;
            if (want_rise ? rise_pulse[ch] : fall_pulse[ch]) n = i;
        end
    endtask

    initial begin
        int n;
        int k;

        // Reset with all buttons high, then a clean press and release on ch0 at T=8.
        for (int i = 0; i < 3; i++) add(1'b1, 4'hF, 11'd8, 4'h0, 4'h0, 4'h0, 1'b0);
        add(1'b0, 4'h0, 11'd8, 4'h0, 4'h0, 4'h0, 1'b0);
        for (int i = 0; i < 9; i++) add(1'b0, 4'h1, 11'd8, 4'h0, 4'h0, 4'h0, 1'b0);
        add(1'b0, 4'h1, 11'd8, 4'h1, 4'h1, 4'h0, 1'b1);
        add(1'b0, 4'h1, 11'd8, 4'h1, 4'h0, 4'h0, 1'b0);
        for (int i = 0; i < 9; i++) add(1'b0, 4'h0, 11'd8, 4'h1, 4'h0, 4'h0, 1'b0);
        add(1'b0, 4'h0, 11'd8, 4'h0, 4'h0, 4'h1, 1'b1);
        add(1'b0, 4'h0, 11'd8, 4'h0, 4'h0, 4'h0, 1'b0);

        reset = 1'b1; btn_input = 4'hF; stable_cycles = 11'd8; clear_flags = 1'b0;
        foreach (tbl[i]) begin
            reset = tbl[i].rst; btn_input = tbl[i].btn;
            stable_cycles = tbl[i].stab; clear_flags = tbl[i].clr;
            step();
            check($sformatf("vec%0d", i),
                  int'({debounce_output, rise_pulse, fall_pulse, bounce_flag, any_change}),
                  int'({tbl[i].out, tbl[i].rise, tbl[i].fall, tbl[i].flag, tbl[i].any}));
        end

        // Bounce on ch1: 1 x3, 0 x3, then held 1. Count aborted at step 6; update at step 16.
        btn_input[1] = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            if (i == 4) btn_input[1] = 1'b0;
            step();
            if (i == 5) check("bounce_flag_before_abort", int'(bounce_flag[1]), 0);
            if (i == 6) check("bounce_flag_set", int'(bounce_flag[1]), 1);
        end
        btn_input[1] = 1'b1;
        k = 0;
        for (int i = 7; i <= 15; i++) begin
            step();
            if (rise_pulse[1] || debounce_output[1]) k++;
        end
        check("bounce_no_early_rise", k, 0);
        wait_pulse(1, 1'b1, 5, n);
        check("bounce_rise_step", n, 1);
        check("bounce_flag_kept", int'(bounce_flag[1]), 1);
        clear_flags = 1'b1;
        step();
        clear_flags = 1'b0;
        check("bounce_flag_cleared", int'(bounce_flag), 0);

        // Threshold 0 behaves as 1: update two edges after capture (step 3).
        stable_cycles = 11'd0;
        btn_input[0] = 1'b1;
        wait_pulse(0, 1'b1, 10, n);
        check("thresh0_rise_step", n, 3);

        // Maximum threshold: update 2048 edges after capture (step 2049), no wrap.
        stable_cycles = 11'd2047;
        btn_input[0] = 1'b0;
        wait_pulse(0, 1'b0, 2100, n);
        check("thresh_max_fall_step", n, 2049);
        check("thresh_max_level", int'(debounce_output[0]), 0);

        // Threshold lowered from 100 to 5 with cnt=20: update on the very next edge.
        stable_cycles = 11'd100;
        btn_input[0] = 1'b1;
        for (int i = 0; i < 22; i++) step();
        check("lower_no_early_update", int'(debounce_output[0]), 0);
        stable_cycles = 11'd5;
        wait_pulse(0, 1'b1, 10, n);
        check("lower_rise_step", n, 1);

        // ch3 up first, then ch2 rise and ch3 fall on the same edge.
        stable_cycles = 11'd2;
        btn_input[3] = 1'b1;
        wait_pulse(3, 1'b1, 10, n);
        check("ch3_rise_step", n, 4);
        step();
        btn_input[2] = 1'b1;
        btn_input[3] = 1'b0;
        wait_pulse(2, 1'b1, 10, n);
        check("simul_rise_step", n, 4);
        check("simul_pulses", int'({rise_pulse, fall_pulse, any_change}), int'({4'b0100, 4'b1000, 1'b1}));
        step();
        check("simul_any_one_cycle", int'({rise_pulse, fall_pulse, any_change}), 0);

        // Flag set and clear_flags on the same edge: set wins.
        stable_cycles = 11'd8;
        btn_input[1] = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            if (i == 4) btn_input[1] = 1'b1;
            step();
        end
        check("flag_before_collision", int'(bounce_flag[1]), 0);
        clear_flags = 1'b1;
        step();
        clear_flags = 1'b0;
        check("flag_set_beats_clear", int'(bounce_flag[1]), 1);
        step();
        check("flag_kept_after_collision", int'(bounce_flag[1]), 1);

        // Reset at cnt=6 of 8 on ch0 falling: no pulse, level returns to RESET_LEVEL.
        btn_input[0] = 1'b0;
        for (int i = 0; i < 8; i++) step();
        check("abort_pre_level", int'(debounce_output[0]), 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("abort_reset_outputs",
              int'({debounce_output, rise_pulse, fall_pulse, bounce_flag, any_change}), 0);
        k = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (fall_pulse[0] || rise_pulse[0]) k++;
        end
        check("abort_no_pulse", k, 0);
        check("abort_level", int'(debounce_output[0]), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
